// File: rtl/md4_range_search.sv
// rtl/md4_range_search.sv - range sweep over parallel md4_pipe lanes with first-match reporting
module md4_pipe #(
    parameter int p_inp_data_len = 32,
    parameter int p_width        = 32
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic [p_inp_data_len-1:0] data,
    output logic [p_width*4-1:0]      digest
);
    // One MD4 step per register stage; the word is a single padded block:
    // X[0]=data, X[1]=0x80 (pad byte), X[14]=bit length, all others zero.
    localparam int n_steps = 48;
    localparam logic [p_width-1:0] iv_a = p_width'(32'h67452301);
    localparam logic [p_width-1:0] iv_b = p_width'(32'hefcdab89);
    localparam logic [p_width-1:0] iv_c = p_width'(32'h98badcfe);
    localparam logic [p_width-1:0] iv_d = p_width'(32'h10325476);

    logic [p_width-1:0] ra [n_steps];
    logic [p_width-1:0] rb [n_steps];
    logic [p_width-1:0] rc [n_steps];
    logic [p_width-1:0] rd [n_steps];
    logic [p_width-1:0] rx [n_steps-1];
    logic [p_width-1:0] ia [n_steps];
    logic [p_width-1:0] ib [n_steps];
    logic [p_width-1:0] ic [n_steps];
    logic [p_width-1:0] id [n_steps];
    logic [p_width-1:0] ix [n_steps];
    logic [p_width-1:0] na [n_steps];

    function automatic logic [p_width-1:0] md4_step(input int i,
            input logic [p_width-1:0] a, b, c, d, x0);
        int j, k, s;
        logic [p_width-1:0] f, kc, xk, t;
        j = i % 16;
        if (i < 16) begin
            f  = (b & c) | (~b & d);
            kc = '0;
            k  = j;
            case (j % 4)
                0: s = 3;
                1: s = 7;
                2: s = 11;
                default: s = 19;
            endcase
        end else if (i < 32) begin
            f  = (b & c) | (b & d) | (c & d);
            kc = p_width'(32'h5a827999);
            k  = (j % 4) * 4 + j / 4;
            case (j % 4)
                0: s = 3;
                1: s = 5;
                2: s = 9;
                default: s = 13;
            endcase
        end else begin
            f  = b ^ c ^ d;
            kc = p_width'(32'h6ed9eba1);
            k  = ((j & 1) << 3) | ((j & 2) << 1) | ((j & 4) >> 1) | ((j & 8) >> 3);
            case (j % 4)
                0: s = 3;
                1: s = 9;
                2: s = 11;
                default: s = 15;
            endcase
        end
        case (k)
            0:       xk = x0;
            1:       xk = p_width'(32'h80);
            14:      xk = p_width'(p_inp_data_len);
            default: xk = '0;
        endcase
        t = a + f + xk + kc;
        return (t << s) | (t >> (p_width - s));
    endfunction

    always_comb begin
        ia[0] = iv_a;
        ib[0] = iv_b;
        ic[0] = iv_c;
        id[0] = iv_d;
        ix[0] = p_width'(data);
        for (int i = 1; i < n_steps; i++) begin
            ia[i] = ra[i-1];
            ib[i] = rb[i-1];
            ic[i] = rc[i-1];
            id[i] = rd[i-1];
            ix[i] = rx[i-1];
        end
        for (int i = 0; i < n_steps; i++) begin
            na[i] = md4_step(i, ia[i], ib[i], ic[i], id[i], ix[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            for (int i = 0; i < n_steps; i++) begin
                ra[i] <= '0;
                rb[i] <= '0;
                rc[i] <= '0;
                rd[i] <= '0;
            end
            for (int i = 0; i < n_steps - 1; i++) rx[i] <= '0;
        end else begin
            for (int i = 0; i < n_steps; i++) begin
                ra[i] <= id[i];
                rb[i] <= na[i];
                rc[i] <= ib[i];
                rd[i] <= ic[i];
            end
            for (int i = 0; i < n_steps - 1; i++) rx[i] <= ix[i];
        end
    end

    assign digest = {ra[n_steps-1] + iv_a, rb[n_steps-1] + iv_b,
                     rc[n_steps-1] + iv_c, rd[n_steps-1] + iv_d};
endmodule

module md4_range_search #(
    parameter int p_inp_data_len = 32,
    parameter int p_width        = 32,
    parameter int p_lanes        = 1,
    parameter int p_pipe_latency = 48
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [p_inp_data_len-1:0] range_lo,
    input  logic [p_inp_data_len-1:0] range_hi,
    input  logic [p_width*4-1:0]      target,
    output logic                      busy,
    output logic                      done,
    output logic                      found,
    output logic [p_inp_data_len-1:0] found_data,
    output logic [p_inp_data_len:0]   attempts
);
    localparam int dw    = p_width * 4;
    localparam int cw    = p_inp_data_len + 1;
    localparam int cnt_w = $clog2(p_pipe_latency + 1);

    typedef enum logic [1:0] {st_idle, st_issue, st_drain, st_done} state_t;
    state_t state, next_state;

    // cand/hi_r carry one extra bit so a range ending at all-ones terminates
    logic [cw-1:0]             cand;
    logic [cw-1:0]             hi_r;
    logic [dw-1:0]             target_r;
    logic [cnt_w-1:0]          drain_cnt;
    logic [p_inp_data_len-1:0] lane_data [p_lanes];
    logic [dw-1:0]             lane_digest [p_lanes];
    logic [p_lanes-1:0]        lane_valid;
    logic [p_lanes-1:0]        tag_valid [p_pipe_latency];
    logic [p_inp_data_len-1:0] tag_base [p_pipe_latency];
    logic [cw-1:0]             valid_count;
    logic                      issue, last_issue, hit, match_any;
    logic [p_inp_data_len-1:0] match_data;

    for (genvar l = 0; l < p_lanes; l++) begin : g_lane
        md4_pipe #(
            .p_inp_data_len(p_inp_data_len),
            .p_width       (p_width)
        ) u_pipe (
            .clk   (clk),
            .rstN  (~rst),
            .data  (lane_data[l]),
            .digest(lane_digest[l])
        );
    end

    always_comb begin
        valid_count = '0;
        lane_valid  = '0;
        for (int l = 0; l < p_lanes; l++) begin
            lane_data[l]  = cand[p_inp_data_len-1:0] + p_inp_data_len'(l);
            lane_valid[l] = (cand + cw'(l)) <= hi_r;
            valid_count   = valid_count + cw'(lane_valid[l]);
        end
    end

    // Descending scan so the lowest matching lane is the one that sticks
    always_comb begin
        match_any  = 1'b0;
        match_data = '0;
        for (int l = p_lanes - 1; l >= 0; l--) begin
            if (tag_valid[p_pipe_latency-1][l] && lane_digest[l] == target_r) begin
                match_any  = 1'b1;
                match_data = tag_base[p_pipe_latency-1] + p_inp_data_len'(l);
            end
        end
    end

    assign hit        = match_any && (state == st_issue || state == st_drain);
    assign issue      = (state == st_issue) && !hit;
    assign last_issue = (cand + cw'(p_lanes)) > hi_r;

    always_ff @(posedge clk) begin
        if (rst) state <= st_idle;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            st_idle: begin
                if (start) next_state = (range_lo <= range_hi) ? st_issue : st_done;
            end
            st_issue: begin
                if (hit)             next_state = st_done;
                else if (last_issue) next_state = st_drain;
            end
            st_drain: begin
                if (hit || drain_cnt == cnt_w'(p_pipe_latency - 1)) next_state = st_done;
            end
            default: next_state = st_idle;
        endcase
    end

    always_comb begin
        busy = (state == st_issue) || (state == st_drain);
        done = (state == st_done);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand       <= '0;
            hi_r       <= '0;
            target_r   <= '0;
            drain_cnt  <= '0;
            found      <= 1'b0;
            found_data <= '0;
            attempts   <= '0;
        end else begin
            if (state == st_idle && start) begin
                cand       <= {1'b0, range_lo};
                hi_r       <= {1'b0, range_hi};
                target_r   <= target;
                found      <= 1'b0;
                found_data <= '0;
                attempts   <= '0;
            end
            if (issue) begin
                cand     <= cand + cw'(p_lanes);
                attempts <= attempts + valid_count;
            end
            if (hit) begin
                found      <= 1'b1;
                found_data <= match_data;
            end
            if (state == st_drain) drain_cnt <= drain_cnt + 1'b1;
            else                   drain_cnt <= '0;
        end
    end

    // Tags ride alongside the pipes so the output slot knows which lanes are live
    always_ff @(posedge clk) begin
        if (rst || next_state == st_idle) begin
            for (int i = 0; i < p_pipe_latency; i++) tag_valid[i] <= '0;
        end else begin
            tag_valid[0] <= issue ? lane_valid : '0;
            for (int i = 1; i < p_pipe_latency; i++) tag_valid[i] <= tag_valid[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_base[0] <= cand[p_inp_data_len-1:0];
        for (int i = 1; i < p_pipe_latency; i++) tag_base[i] <= tag_base[i-1];
    end
endmodule

// File: tb/tb_md4_range_search.sv
// tb/tb_md4_range_search.sv - scoreboard bench for md4_range_search with 1-lane and 4-lane instances
module tb_md4_range_search;
    localparam int lat = 48;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [31:0]  range_lo, range_hi;
    logic [127:0] target;
    logic         busy1, done1, found1, busy4, done4, found4;
    logic [31:0]  fd1, fd4;
    logic [32:0]  att1, att4;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic        found;
        logic [31:0] data;
        logic [32:0] att;
        int          lat;
        int          st;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    logic prev_done1 = 1'b0;
    logic prev_done4 = 1'b0;

    int k2_tab [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    int k3_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int s1_tab [4]  = '{3, 7, 11, 19};
    int s2_tab [4]  = '{3, 5, 9, 13};
    int s3_tab [4]  = '{3, 9, 11, 15};

    md4_range_search #(.p_inp_data_len(32), .p_width(32), .p_lanes(1), .p_pipe_latency(lat)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .range_lo(range_lo), .range_hi(range_hi),
        .target(target), .busy(busy1), .done(done1), .found(found1), .found_data(fd1),
        .attempts(att1));

    md4_range_search #(.p_inp_data_len(32), .p_width(32), .p_lanes(4), .p_pipe_latency(lat)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .range_lo(range_lo), .range_hi(range_hi),
        .target(target), .busy(busy4), .done(done4), .found(found4), .found_data(fd4),
        .attempts(att4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // MD4 of one 32-bit word as a single padded 512-bit block
    function automatic logic [127:0] md4w(input logic [31:0] w);
        logic [31:0] x [16];
        logic [31:0] a, b, c, d, f, t, kc;
        int j, k, s;
        x = '{default: 32'h0};
        x[0] = w;
        x[1] = 32'h80;
        x[14] = 32;
        a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
        for (int i = 0; i < 48; i++) begin
            j = i % 16;
            if (i < 16) begin
                f = (b & c) | (~b & d); k = j; kc = 32'h0; s = s1_tab[j % 4];
            end else if (i < 32) begin
                f = (b & c) | (b & d) | (c & d); k = k2_tab[j]; kc = 32'h5a827999; s = s2_tab[j % 4];
            end else begin
                f = b ^ c ^ d; k = k3_tab[j]; kc = 32'h6ed9eba1; s = s3_tab[j % 4];
            end
            t = a + f + x[k] + kc;
            t = (t << s) | (t >> (32 - s));
            a = d; d = c; c = b; b = t;
        end
        return {a + 32'h67452301, b + 32'hefcdab89, c + 32'h98badcfe, d + 32'h10325476};
    endfunction

    // Expected outcome: first candidate in range order whose digest hits; issue keeps
    // running until the match reaches the compare slot, lat cycles after its issue.
    function automatic exp_t model(input logic [31:0] lo, input logic [31:0] hi,
                                   input logic [127:0] tgt, input int lanes, input int st);
        exp_t e;
        longint total, idx, beats, kb, lim;
        e.st = st;
        e.found = 1'b0;
        e.data = 32'h0;
        e.att = 33'h0;
        if (lo > hi) begin
            e.lat = 1;
            return e;
        end
        total = longint'(hi) - longint'(lo) + 1;
        idx = -1;
        for (longint i = 0; i < total; i++) begin
            if (md4w(32'(longint'(lo) + i)) == tgt) begin
                idx = i;
                break;
            end
        end
        beats = (total + lanes - 1) / lanes;
        if (idx >= 0) begin
            kb = idx / lanes;
            lim = (kb + lat) * lanes;
            e.found = 1'b1;
            e.data = 32'(longint'(lo) + idx);
            e.att = 33'((lim < total) ? lim : total);
            e.lat = int'(kb) + lat + 2;
        end else begin
            e.att = 33'(total);
            e.lat = int'(beats) + lat + 1;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic check_done(input string tag, input exp_t e, input logic b, input logic f,
                              input logic [31:0] fd, input logic [32:0] at, input logic pd);
        chk({tag, "_found"}, 64'(f), 64'(e.found));
        chk({tag, "_found_data"}, 64'(fd), 64'(e.data));
        chk({tag, "_attempts"}, 64'(at), 64'(e.att));
        chk({tag, "_busy_at_done"}, 64'(b), 64'h0);
        chk({tag, "_done_cycle"}, 64'(cyc - e.st), 64'(e.lat));
        chk({tag, "_done_one_cycle"}, 64'(pd), 64'h0);
    endtask

    always @(negedge clk) begin
        if (!rst && done1) begin
            if (q1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL lane1_spurious_done: done=1, required 0");
            end else begin
                check_done("lane1", q1.pop_front(), busy1, found1, fd1, att1, prev_done1);
            end
        end
        prev_done1 <= done1;
    end

    always @(negedge clk) begin
        if (!rst && done4) begin
            if (q4.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL lane4_spurious_done: done=1, required 0");
            end else begin
                check_done("lane4", q4.pop_front(), busy4, found4, fd4, att4, prev_done4);
            end
        end
        prev_done4 <= done4;
    end

    task automatic run(input logic [31:0] lo, input logic [31:0] hi, input logic [127:0] tgt,
                       input bit push, input bit dup_start, input int abort_after);
        int st, waited;
        bit saw_busy;
        @(negedge clk);
        range_lo = lo;
        range_hi = hi;
        target = tgt;
        start = 1'b1;
        st = cyc;
        if (push) begin
            q1.push_back(model(lo, hi, tgt, 1, st));
            q4.push_back(model(lo, hi, tgt, 4, st));
        end
        @(negedge clk);
        start = 1'b0;
        saw_busy = busy1 | busy4;
        waited = 0;
        if (abort_after > 0) begin
            repeat (abort_after) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("reset_busy1", 64'(busy1), 64'h0);
            chk("reset_busy4", 64'(busy4), 64'h0);
            chk("reset_found1", 64'(found1), 64'h0);
            chk("reset_attempts1", 64'(att1), 64'h0);
            chk("reset_attempts4", 64'(att4), 64'h0);
            repeat (lat + 20) @(negedge clk);
            return;
        end
        while ((q1.size() != 0 || q4.size() != 0) && waited < 400) begin
            if (dup_start && waited == 5) begin
                range_lo = 32'h0;
                range_hi = 32'd100;
                target = md4w(32'd3);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            saw_busy = saw_busy | busy1 | busy4;
            waited++;
        end
        start = 1'b0;
        if (q1.size() != 0 || q4.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: waited %0d cycles, required done from both lanes", waited);
            q1.delete();
            q4.delete();
        end
        if (lo > hi) chk("empty_busy_seen", 64'(saw_busy), 64'h0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [31:0] lo, hi, pick;
        int size, kind;
        rst = 1'b1;
        start = 1'b0;
        range_lo = '0;
        range_hi = '0;
        target = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy1", 64'(busy1), 64'h0);
        chk("rst_done1", 64'(done1), 64'h0);
        chk("rst_found1", 64'(found1), 64'h0);
        chk("rst_found_data1", 64'(fd1), 64'h0);
        chk("rst_attempts1", 64'(att1), 64'h0);
        chk("rst_busy4", 64'(busy4), 64'h0);
        chk("rst_attempts4", 64'(att4), 64'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(32'h12345670, 32'h1234567F, md4w(32'h12345678), 1, 0, 0);
        run(32'h00000000, 32'h00000007, 128'h0, 1, 0, 0);
        run(32'h00000010, 32'h0000000F, md4w(32'h10), 1, 0, 0);
        run(32'h12345670, 32'h12345679, md4w(32'h12345679), 1, 0, 0);
        run(32'h12345670, 32'h12345679, md4w(32'h1234567A), 1, 0, 0);
        run(32'hFFFFFFFE, 32'hFFFFFFFF, 128'h0, 1, 1, 0);
        run(32'hFFFFFFFE, 32'hFFFFFFFF, md4w(32'hFFFFFFFF), 1, 0, 0);
        run(32'h12345670, 32'h1234567F, md4w(32'h12345678), 0, 0, 4);
        run(32'h12345670, 32'h1234567F, md4w(32'h12345678), 1, 0, 0);

        for (int n = 0; n < 8; n++) begin
            lo = $urandom;
            size = $urandom_range(1, 20);
            hi = (longint'(lo) + size - 1 > 64'hFFFFFFFF) ? 32'hFFFFFFFF : lo + 32'(size - 1);
            kind = $urandom_range(0, 3);
            pick = lo + 32'($urandom_range(0, size - 1));
            if (pick > hi || pick < lo) pick = hi;
            case (kind)
                0:       target = md4w(pick);
                1:       target = md4w(hi + 32'h1);
                2:       target = {$urandom, $urandom, $urandom, $urandom};
                default: target = md4w(hi);
            endcase
            run(lo, hi, target, 1, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
